// File: rtl/bb84_sift_engine_pkg.sv
// rtl/bb84_sift_engine_pkg.sv - shared types, basis constants and width helper for the BB84 sift engine
package bb84_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        KEY,
        CHECK,
        DONE,
        ABORT
    } state_t;

    localparam logic BASIS_RECT = 1'b0;
    localparam logic BASIS_DIAG = 1'b1;

    // Width of a counter that must hold every value 0..n without wrapping.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bb84_sift_engine_if.sv
// rtl/bb84_sift_engine_if.sv - photon record handshake bundle
//   in_valid/in_ready : record handshake
//   alice_bit, alice_basis, bob_basis, bob_bit : record fields
interface bb84_sift_engine_if;
    logic in_valid;
    logic in_ready;
    logic alice_bit;
    logic alice_basis;
    logic bob_basis;
    logic bob_bit;

    modport master (
        output in_valid, alice_bit, alice_basis, bob_basis, bob_bit,
        input  in_ready
    );

    modport slave (
        input  in_valid, alice_bit, alice_basis, bob_basis, bob_bit,
        output in_ready
    );
endinterface

// File: rtl/bb84_sift_engine_sift_unit.sv
// rtl/bb84_sift_engine_sift_unit.sv - combinational per-record basis sift and bit compare
//   inputs : alice_bit, alice_basis, bob_basis, bob_bit
//   outputs: sifted (bases agree), mismatch (Alice and Bob bits differ)
module bb84_sift_unit
    import bb84_pkg::*;
(
    input  logic alice_bit,
    input  logic alice_basis,
    input  logic bob_basis,
    input  logic bob_bit,
    output logic sifted,
    output logic mismatch
);
    assign sifted   = (alice_basis == bob_basis);
    assign mismatch = alice_bit ^ bob_bit;
endmodule

// File: rtl/bb84_sift_engine.sv
// rtl/bb84_sift_engine.sv - clocked BB84 sifting engine: sample-phase QBER check then key assembly
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : begin a session (honoured in IDLE, DONE, ABORT)
//   rec               : photon record stream (slave side)
//   key_out/key_valid : sifted key, first key bit at MSB, valid in DONE
//   abort/timeout     : session aborted; timeout marks MAX_PHOTONS as the cause
//   sample_err/key_err: mismatch counts in sample and key bits
//   busy              : SAMPLE or KEY
module bb84_sift_engine
    import bb84_pkg::*;
#(
    parameter int KEY_LEN     = 16,
    parameter int SAMPLE_LEN  = 4,
    parameter int ERR_THRESH  = 0,
    parameter int MAX_PHOTONS = 256,
    parameter int CNT_W       = $clog2(MAX_PHOTONS + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    bb84_sift_engine_if.slave                 rec,
    output logic [KEY_LEN-1:0]                key_out,
    output logic                              key_valid,
    output logic                              abort,
    output logic                              timeout,
    output logic [$clog2(SAMPLE_LEN+1)-1:0]   sample_err,
    output logic [$clog2(KEY_LEN+1)-1:0]      key_err,
    output logic                              busy
);
    localparam int SW = cnt_width(SAMPLE_LEN);
    localparam int KW = cnt_width(KEY_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] photon_cnt;
    logic [SW-1:0]    sample_cnt;
    logic [KW-1:0]    key_cnt;
    logic             sifted, mismatch, accept;
    logic             session_start, timeout_set;
    logic             photon_last, sample_last, key_last;

    bb84_sift_unit u_sift (
        .alice_bit   (rec.alice_bit),
        .alice_basis (rec.alice_basis),
        .bob_basis   (rec.bob_basis),
        .bob_bit     (rec.bob_bit),
        .sifted      (sifted),
        .mismatch    (mismatch)
    );

    assign accept = rec.in_valid & rec.in_ready;

    // ">=" rather than "==": if the sample phase completes on the MAX_PHOTONS-th
    // record, the counter sits at MAX and the very next key-phase record times out.
    assign photon_last = (photon_cnt >= CNT_W'(MAX_PHOTONS - 1));
    assign sample_last = (sample_cnt == SW'(SAMPLE_LEN - 1));
    assign key_last    = (key_cnt == KW'(KEY_LEN - 1));

    always_comb begin
        state_d       = state_q;
        rec.in_ready  = 1'b0;
        busy          = 1'b0;
        key_valid     = 1'b0;
        abort         = 1'b0;
        session_start = 1'b0;
        timeout_set   = 1'b0;
        case (state_q)
            IDLE, DONE, ABORT: begin
                key_valid = (state_q == DONE);
                abort     = (state_q == ABORT);
                if (start) begin
                    session_start = 1'b1;
                    state_d       = SAMPLE;
                end
            end
            SAMPLE: begin
                rec.in_ready = 1'b1;
                busy         = 1'b1;
                if (rec.in_valid) begin
                    if (sifted && sample_last) begin
                        state_d = KEY;
                    end else if (photon_last) begin
                        state_d     = ABORT;
                        timeout_set = 1'b1;
                    end
                end
            end
            KEY: begin
                rec.in_ready = 1'b1;
                busy         = 1'b1;
                if (rec.in_valid) begin
                    // Completing the key takes priority over the photon budget.
                    if (sifted && key_last) begin
                        state_d = CHECK;
                    end else if (photon_last) begin
                        state_d     = ABORT;
                        timeout_set = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = (int'(sample_err) > ERR_THRESH) ? ABORT : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            photon_cnt <= '0;
            sample_cnt <= '0;
            key_cnt    <= '0;
            key_out    <= '0;
            sample_err <= '0;
            key_err    <= '0;
            timeout    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (session_start) begin
                photon_cnt <= '0;
                sample_cnt <= '0;
                key_cnt    <= '0;
                key_out    <= '0;
                sample_err <= '0;
                key_err    <= '0;
                timeout    <= 1'b0;
            end else if (accept) begin
                if (photon_cnt != CNT_W'(MAX_PHOTONS))
                    photon_cnt <= photon_cnt + CNT_W'(1);
                if (sifted) begin
                    if (state_q == SAMPLE) begin
                        sample_cnt <= sample_cnt + SW'(1);
                        sample_err <= sample_err + SW'(mismatch);
                    end else begin
                        key_out <= KEY_LEN'({key_out, rec.bob_bit});
                        key_err <= key_err + KW'(mismatch);
                        key_cnt <= key_cnt + KW'(1);
                    end
                end
                if (timeout_set)
                    timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bb84_sift_engine.sv
// tb/tb_bb84_sift_engine.sv - self-checking bench for bb84_sift_engine
module tb_bb84_sift_engine;
    import bb84_pkg::*;

    localparam int K   = 4;
    localparam int S   = 2;
    localparam int THR = 0;
    localparam int MAXP = 8;

    typedef struct packed {
        logic ab;
        logic aba;
        logic bba;
        logic bb;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [K-1:0] key_out;
    logic         key_valid, abort, timeout, busy;
    logic [1:0]   sample_err;
    logic [2:0]   key_err;

    bb84_sift_engine_if ifc ();

    bb84_sift_engine #(
        .KEY_LEN     (K),
        .SAMPLE_LEN  (S),
        .ERR_THRESH  (THR),
        .MAX_PHOTONS (MAXP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rec        (ifc.slave),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .abort      (abort),
        .timeout    (timeout),
        .sample_err (sample_err),
        .key_err    (key_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    rec_t         recs[$];
    int           m_used, m_serr, m_kerr;
    logic         m_done, m_to;
    logic [K-1:0] m_key;

    // Reference: walk the record list, carving sifted bits into a sample
    // block and then a key block, and stop at completion or the photon budget.
    task automatic model();
        int  ns, nk;
        logic complete, phase_done;
        ns = 0; nk = 0; m_serr = 0; m_kerr = 0; m_key = '0;
        m_used = 0; complete = 0; m_to = 0;
        for (int i = 0; i < recs.size(); i++) begin
            phase_done = 0;
            m_used = i + 1;
            if (recs[i].aba == recs[i].bba) begin
                if (ns < S) begin
                    ns++;
                    if (recs[i].ab != recs[i].bb) m_serr++;
                    phase_done = (ns == S);
                end else begin
                    m_key[K-1-nk] = recs[i].bb;
                    if (recs[i].ab != recs[i].bb) m_kerr++;
                    nk++;
                    if (nk == K) begin
                        complete = 1;
                        break;
                    end
                end
            end
            if (!phase_done && m_used >= MAXP) begin
                m_to = 1;
                break;
            end
        end
        m_done = complete && (m_serr <= THR);
    endtask

    task automatic send_rec(input rec_t r, input logic also_start);
        logic got;
        ifc.in_valid    = 1'b1;
        ifc.alice_bit   = r.ab;
        ifc.alice_basis = r.aba;
        ifc.bob_basis   = r.bba;
        ifc.bob_bit     = r.bb;
        start           = also_start;
        got = 0;
        for (int c = 0; c < 16 && !got; c++) begin
            if (ifc.in_ready) got = 1;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", ifc.in_ready, 1);
        chk("start_key_valid", key_valid, 0);
        chk("start_abort", abort, 0);
        chk("start_timeout", timeout, 0);
        chk("start_sample_err", sample_err, 0);
        chk("start_key_err", key_err, 0);
        chk("start_key_out", key_out, 0);
    endtask

    task automatic run_session(input int ign_idx, input logic use_lit, input logic [K-1:0] lit_key);
        model();
        do_start();
        for (int i = 0; i < m_used; i++) send_rec(recs[i], i == ign_idx);
        if (m_to) begin
            chk("to_abort", abort, 1);
            chk("to_timeout", timeout, 1);
            chk("to_key_valid", key_valid, 0);
            chk("to_busy", busy, 0);
        end else begin
            chk("check_key_valid", key_valid, 0);
            chk("check_abort", abort, 0);
            chk("check_in_ready", ifc.in_ready, 0);
            @(posedge clk);
            @(negedge clk);
            chk("end_key_valid", key_valid, m_done);
            chk("end_abort", abort, !m_done);
            chk("end_timeout", timeout, 0);
            if (m_done) chk("end_key_out", key_out, m_key);
            if (m_done && use_lit) chk("end_key_literal", key_out, lit_key);
        end
        chk("end_sample_err", sample_err, m_serr);
        chk("end_key_err", key_err, m_kerr);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_in_ready", ifc.in_ready, 0);
            if (m_done) chk("hold_key_out", key_out, m_key);
        end
        ifc.in_valid = 1'b0;
    endtask

    function automatic rec_t sifted_rec(input logic ab, input logic flip);
        rec_t r;
        r.ab  = ab;
        r.aba = 1'($urandom_range(0, 1));
        r.bba = r.aba;
        r.bb  = ab ^ flip;
        return r;
    endfunction

    function automatic rec_t unsifted_rec();
        rec_t r;
        r.ab  = 1'($urandom_range(0, 1));
        r.aba = BASIS_DIAG;
        r.bba = BASIS_RECT;
        r.bb  = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic build_clean(input logic interleave, input int flip_idx);
        logic [5:0] bits;
        bits = 6'b101101;
        recs.delete();
        for (int i = 0; i < 6; i++) begin
            recs.push_back(sifted_rec(bits[5-i], i == flip_idx));
            if (interleave && (i == 1 || i == 3)) recs.push_back(unsifted_rec());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid = 0; ifc.alice_bit = 0; ifc.alice_basis = 0;
        ifc.bob_basis = 0; ifc.bob_bit = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_abort", abort, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_key_out", key_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        build_clean(0, -1);
        run_session(-1, 1, 4'b1101);

        // Eight records with the last one completing the key: CHECK beats the budget.
        build_clean(1, -1);
        run_session(-1, 1, 4'b1101);

        build_clean(0, 1);
        run_session(-1, 0, 4'b0000);
        chk("eve_abort", abort, 1);
        chk("eve_timeout", timeout, 0);

        recs.delete();
        for (int i = 0; i < 10; i++) recs.push_back(unsifted_rec());
        run_session(-1, 0, 4'b0000);
        chk("all_unsifted_used", m_used, MAXP);

        build_clean(0, -1);
        do_start();
        for (int i = 0; i < 3; i++) send_rec(recs[i], 0);
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", ifc.in_ready, 0);
        chk("midrst_key_out", key_out, 0);
        chk("midrst_key_err", key_err, 0);
        chk("midrst_sample_err", sample_err, 0);
        run_session(-1, 1, 4'b1101);

        build_clean(1, -1);
        run_session(4, 1, 4'b1101);

        for (int s = 0; s < 30; s++) begin
            recs.delete();
            for (int i = 0; i < 12; i++) begin
                rec_t r;
                r.ab  = 1'($urandom_range(0, 1));
                r.aba = 1'($urandom_range(0, 1));
                r.bba = ($urandom_range(0, 3) == 0) ? ~r.aba : r.aba;
                r.bb  = r.ab ^ ($urandom_range(0, 9) == 0);
                recs.push_back(r);
            end
            run_session((s % 3 == 0) ? 2 : -1, 0, 4'b0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bb84_sift_engine.md
Name: bb84_sift_engine

Overview:
- Clocked, parametrised successor to the combinational single-photon BB84 top level; streams one photon record per handshake.
- Each record carries Alice's bit and basis plus Bob's basis and measured bit.
- Discards basis mismatches and spends the first SAMPLE_LEN sifted bits on error estimation (QBER check), then assembles a KEY_LEN-bit sifted key.
- Sits between the photon/channel model (including the spy model) and the key consumer.

Parameters:
- KEY_LEN, 16, sifted key bits delivered per session (>=1)
- SAMPLE_LEN, 4, sifted bits sacrificed for error estimation (>=1)
- ERR_THRESH, 0, max tolerated sample mismatches; above this the session aborts
- MAX_PHOTONS, 256, photon records accepted per session before timeout abort
- CNT_W, $clog2(MAX_PHOTONS+1), photon counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin session; sampled only in IDLE, DONE or ABORT
- in_valid  in  1  photon record valid
- in_ready  out  1  engine accepts record this cycle
- alice_bit  in  1  Alice raw bit
- alice_basis  in  1  Alice basis (0 rectilinear, 1 diagonal)
- bob_basis  in  1  Bob measurement basis
- bob_bit  in  1  Bob measured bit (may be corrupted by spy/channel)
- key_out  out  KEY_LEN  sifted key, first sifted key bit at MSB
- key_valid  out  1  key_out valid (DONE)
- abort  out  1  session aborted (ABORT)
- timeout  out  1  abort cause was MAX_PHOTONS, qualified by abort
- sample_err  out  $clog2(SAMPLE_LEN+1)  mismatches found in sample phase
- key_err  out  $clog2(KEY_LEN+1)  Alice/Bob mismatches inside key bits (verification visibility only)
- busy  out  1  state is SAMPLE or KEY

Behaviour:
- States: IDLE, SAMPLE, KEY, CHECK, DONE, ABORT.
- Reset (rst_n=0 at clk edge), from any state including mid-session: state IDLE; all counters, key_out, sample_err and key_err cleared; in_ready, key_valid, abort, timeout and busy all 0.
- IDLE/DONE/ABORT with start=1: go to SAMPLE next cycle; clear counters, key_out, sample_err, key_err, key_valid, abort and timeout.
- in_ready=1 only in SAMPLE and KEY; a record is accepted when in_valid & in_ready.
- Every accepted record increments photon_cnt.
- Sifted record: alice_basis==bob_basis. Unsifted records are discarded with no other effect.
- SAMPLE, sifted record: sample_cnt++; sample_err++ if alice_bit!=bob_bit.
  - When sample_cnt reaches SAMPLE_LEN on this record, go to KEY.
  - Sample bits never enter the key.
- KEY, sifted record: key_out <= {key_out[KEY_LEN-2:0], bob_bit}; key_err++ if alice_bit!=bob_bit; key_cnt++.
  - When key_cnt reaches KEY_LEN, go to CHECK.
- CHECK, one cycle, in_ready=0: if sample_err > ERR_THRESH go to ABORT, else go to DONE.
- DONE: key_valid=1; key_out held stable until next start or reset.
- ABORT: abort=1; key_out content is don't-care.
- Timeout: in SAMPLE or KEY, an accepted record that makes photon_cnt == MAX_PHOTONS without completing the current phase -> ABORT with timeout=1.
  - If that same record completes KEY, CHECK wins and timeout stays 0.
- Latency: key_valid or abort asserts 2 cycles after the final qualifying handshake (one cycle in CHECK).
- start while busy: ignored.
- in_valid with in_ready=0: record not consumed; upstream must hold it.
- All counters saturate-free by construction; widths sized so no wrap is possible.

Decomposition:
- Package bb84_pkg holds:
  - state enum (IDLE..ABORT)
  - basis constants BASIS_RECT=0, BASIS_DIAG=1
  - localparam width helpers
- One natural sub-module, bb84_sift_unit: combinational; inputs are the record fields; outputs are sifted and mismatch.

Test Plan:
- Override KEY_LEN=4, SAMPLE_LEN=2, ERR_THRESH=0 for the directed tests below.
- Clean session: start, then 6 sifted records, Alice bits 1,0,1,1,0,1, bob_bit==alice_bit -> key_out=4'b1101, key_valid=1 two cycles after the 6th handshake, sample_err=0, key_err=0.
- Basis filter: the clean sequence with unsifted records interleaved (alice_basis=1, bob_basis=0, as in the original mismatched-basis cases) -> identical key_out=4'b1101; photon_cnt counts all records.
- Eavesdrop detection: second sample record has bob_bit!=alice_bit -> sample_err=1 > 0 -> abort=1, timeout=0, key_valid=0.
- Timeout: MAX_PHOTONS=8, feed 8 all-unsifted records -> abort=1 and timeout=1 after the 8th handshake; in_ready=0 afterwards.
- Reset mid-session: rst_n=0 for one edge after 3 sifted records -> IDLE; outputs at reset values; a fresh start plus the clean session -> key_out=4'b1101.
- Back-pressure/restart: in_valid held high through CHECK and DONE -> no extra records consumed; start while busy ignored; start in DONE clears key_valid next cycle.
